codec_reg_arbiter: RTL and testbench
====================================

// Module: codec_reg_arbiter
// PURPOSE
// - Shares the single CODEC register RD/WR port of the codec controller unit (rd_en/wr_en/addr/data/busy)
//   between NUM_REQ requesters, e.g. the AXI register bank, the volume ramp engine and the sample-rate switcher.
// - Round-robin grant; one transaction outstanding; response routed back to the owning requester only.
// PARAMETERS
// - NUM_REQ         3      number of requesters, 2..8
// - TIMEOUT_CYCLES  65535  max cycles per transaction before abort; used only with CODEC_ARB_TIMEOUT_EN
// PORTS
// - clk                   in   1          system clock; single clock domain
// - reset                 in   1          synchronous, active-high
// - req_valid             in   NUM_REQ    request pending; payload stable while high
// - req_write             in   NUM_REQ    1=write, 0=read
// - req_addr              in   8*NUM_REQ  CODEC register address; slice i = [8i+7:8i]
// - req_wdata             in   8*NUM_REQ  write data
// - req_ready             out  NUM_REQ    one-cycle accept pulse to the granted requester
// - rsp_valid             out  NUM_REQ    one-cycle completion pulse to the owner
// - rsp_rdata             out  8          read data; valid with rsp_valid; 0 for writes
// - rsp_error             out  NUM_REQ    qualifies rsp_valid: transaction timed out
// - codec_rd_en           out  1          one-cycle read strobe to the controller
// - codec_wr_en           out  1          one-cycle write strobe
// - codec_reg_addr        out  8          held from ISSUE until the transaction completes
// - codec_data_in         out  8          write data, held like codec_reg_addr
// - codec_data_out        in   8          read data from the controller
// - codec_data_out_valid  in   1          read data strobe
// - controller_busy       in   1          high during init and while a transaction is in flight
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; RR pointer = NUM_REQ-1, so req 0 wins first.
// - IDLE: if any req_valid and controller_busy==0, pick the first set bit at or after pointer+1 (wrapping).
//   Same cycle: latch the payload, set owner and pointer, pulse req_ready[owner], go to ISSUE.
//   While controller_busy==1 (e.g. codec init), no grant.
// - ISSUE (1 cycle): pulse codec_wr_en or codec_rd_en; go to WAIT_BUSY.
// - WAIT_BUSY: wait for controller_busy==1, then go to WAIT_DONE.
// - WAIT_DONE:
//   - Read: capture codec_data_out on codec_data_out_valid.
//   - On controller_busy==0 go to RESP. A read with no valid strobe returns the last captured value (0 after reset).
// - RESP (1 cycle): rsp_valid[owner]=1; rsp_rdata = captured data for reads, 0 for writes; go to IDLE.
//   No grant in this cycle.
// - Latency with an instant controller: grant at cycle T, strobe at T+1, rsp_valid at the earliest at T+4.
// - Next grant at the earliest in the cycle after RESP, so back-to-back grants are >=1 idle cycle apart.
// - Dropping req_valid after req_ready has no effect; the accepted transaction completes.
// - A requester may re-request in the cycle after rsp_valid. RR fairness means it waits if others are pending.
// - Simultaneous req_valid: only one req_ready bit is ever set. rsp_valid is one-hot or zero.
// - Reset mid-transaction: abort to IDLE silently, no rsp_valid. Outputs return to reset values the next cycle.
// - Unused upper address bits do not exist; all widths are exact. Owner index is $clog2(NUM_REQ) bits.
// CONFIGURATION
// - CODEC_ARB_TIMEOUT_EN defined:
//   - A 16-bit cycle counter clears at ISSUE and counts in WAIT_BUSY and WAIT_DONE.
//   - When it reaches TIMEOUT_CYCLES, go to RESP with rsp_error[owner]=1 and rsp_rdata=0.
//   - The strobes stay low; the next grant is still gated by controller_busy==0.
// - Not defined: no counter; waits indefinitely; rsp_error tied to 0.
// STRUCTURE
// - Package codec_arb_pkg: arb_state_t enum {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP};
//   CODEC_ADDR_W=8, CODEC_DATA_W=8; MAX_REQ=8.
// - Sub-module rr_arbiter:
//   - Inputs: request vector and pointer.
//   - Outputs: one-hot grant and grant index.
//   - Combinational pick; the pointer register lives in the top.
// - Top: FSM, payload/owner latches, data capture, optional timeout counter.
// TESTING
// - Single write:
//   - Stimulus: req1 wr addr 0x10 data 0xA5; model raises busy 2 cycles after wr_en, holds 5 cycles.
//   - Response: one wr_en pulse with addr 0x10 / data 0xA5; then rsp_valid[1], rsp_error=0.
// - Read: req0 rd addr 0x22, model returns 0x3C with data_out_valid -> rsp_valid[0], rsp_rdata=0x3C.
// - Fairness: all 3 req_valid held high from reset -> grant order 0,1,2,0,1,2; no double req_ready.
// - Init gating: controller_busy high for 100 cycles after reset with req2 pending -> no strobe until busy falls.
//   The grant follows within 1 cycle.
// - Timeout (CODEC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): model never raises busy.
//   Expect rsp_valid[0] with rsp_error[0]=1 and rsp_rdata=0 exactly 21 cycles after ISSUE.
// - Reset asserted in WAIT_DONE -> no rsp_valid; next request after reset is granted normally to req0 first.

Source files
------------

// File: rtl/codec_arb_pkg.sv
// ----------------------------------------------------------------------------
// codec_arb_pkg
//   Shared types and constants for the CODEC register-port arbiter.
//   - arb_state_t : transaction FSM states of codec_reg_arbiter
//   - CODEC_ADDR_W / CODEC_DATA_W : exact widths of the controller register port
//   - MAX_REQ : upper bound on the number of requesters sharing the port
//   - TIMER_W : width of the optional per-transaction timeout counter
// ----------------------------------------------------------------------------
package codec_arb_pkg;

  localparam int CODEC_ADDR_W = 8;
  localparam int CODEC_DATA_W = 8;
  localparam int MAX_REQ      = 8;
  localparam int TIMER_W      = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Searches the request vector starting
//   at ptr+1 (wrapping) and returns the first set bit. The pointer register is
//   owned by the instantiating block, which updates it on an actual grant.
//
//   Ports
//     req      in   NUM_REQ  request vector
//     ptr      in   IDX_W    index of the most recently granted requester
//     gnt      out  NUM_REQ  one-hot grant (all zero when nothing requests)
//     gnt_idx  out  IDX_W    binary index of the granted requester
//     gnt_any  out  1        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
  import codec_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every requester exactly once, the previous
  // winner last, which is what gives the rotating priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/codec_reg_arbiter.sv
// ----------------------------------------------------------------------------
// codec_reg_arbiter
//   Shares the single CODEC controller register port (rd/wr strobe, address,
//   data, busy handshake) between NUM_REQ requesters such as the AXI register
//   bank, the volume ramp engine and the sample-rate switcher. Round-robin
//   grant, one transaction outstanding, response routed only to its owner.
//
//   Optional feature macro: CODEC_ARB_TIMEOUT_EN
//     defined   : a 16-bit counter aborts a transaction after TIMEOUT_CYCLES
//                 cycles of waiting and answers with rsp_error[owner]=1.
//     undefined : transactions wait indefinitely; rsp_error is always 0.
//
//   Parameters
//     NUM_REQ         number of requesters, 2..8
//     TIMEOUT_CYCLES  wait-cycle limit (only with CODEC_ARB_TIMEOUT_EN)
//
//   Ports
//     clk, reset            clock; synchronous active-high reset
//     req_valid/write       per-requester request and direction (1 = write)
//     req_addr/req_wdata    per-requester 8-bit slices, slice i = [8i+7:8i]
//     req_ready             one-cycle accept pulse to the granted requester
//     rsp_valid/rsp_error   one-cycle completion pulse (and timeout flag)
//     rsp_rdata             read data with rsp_valid; 0 for writes/timeouts
//     codec_rd_en/wr_en     one-cycle strobes to the controller
//     codec_reg_addr        address, held from ISSUE until completion
//     codec_data_in         write data, held like the address
//     codec_data_out(_valid) read data and its strobe from the controller
//     controller_busy       controller init / transaction in flight
// ----------------------------------------------------------------------------
module codec_reg_arbiter
  import codec_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [CODEC_ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [CODEC_DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [CODEC_DATA_W-1:0]          rsp_rdata,
  output logic [NUM_REQ-1:0]               rsp_error,
  output logic                             codec_rd_en,
  output logic                             codec_wr_en,
  output logic [CODEC_ADDR_W-1:0]          codec_reg_addr,
  output logic [CODEC_DATA_W-1:0]          codec_data_in,
  input  logic [CODEC_DATA_W-1:0]          codec_data_out,
  input  logic                             codec_data_out_valid,
  input  logic                             controller_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Elaboration-time guard on the configuration range.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_config
    $error("codec_reg_arbiter: NUM_REQ must be 2..%0d and TIMEOUT_CYCLES 1..65535",
           MAX_REQ);
  end

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        owner_q;
  logic                    is_write_q;
  logic [CODEC_ADDR_W-1:0] addr_q;
  logic [CODEC_DATA_W-1:0] wdata_q;
  logic [CODEC_DATA_W-1:0] rdata_q;
  logic                    err_q;
  logic                    timeout_hit;

  logic [NUM_REQ-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_any;
  logic                    grant;
  logic [NUM_REQ-1:0]      owner_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // A grant needs an idle FSM and an idle controller. Reset masks it so a
  // requester never sees an accept that the register update discards.
  assign grant    = (state_q == IDLE) && gnt_any && !controller_busy && !reset;
  assign owner_oh = NUM_REQ'(1) << owner_q;

`ifdef CODEC_ARB_TIMEOUT_EN
  logic [TIMER_W-1:0] cnt_q;
  logic               waiting;

  assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

  // Counter is 0 in the first wait cycle, so the abort fires in the cycle
  // where the count would reach TIMEOUT_CYCLES and RESP lands
  // TIMEOUT_CYCLES+1 cycles after ISSUE.
  always_comb begin
    timeout_hit = waiting &&
                  ((cnt_q + TIMER_W'(1)) == TIMER_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (waiting) begin
      cnt_q <= cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (grant) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. Normal progress takes priority over a timeout
  // that happens to expire in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (controller_busy) begin
          state_d = WAIT_DONE;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      WAIT_DONE: begin
        if (!controller_busy) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload and owner are captured at grant time so the requester may drop
  // or change its request as soon as it has seen req_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (grant) begin
      ptr_q      <= gnt_idx;
      owner_q    <= gnt_idx;
      is_write_q <= req_write[gnt_idx];
      addr_q     <= req_addr[CODEC_ADDR_W*gnt_idx +: CODEC_ADDR_W];
      wdata_q    <= req_wdata[CODEC_DATA_W*gnt_idx +: CODEC_DATA_W];
    end
  end

  // Read data is sticky: a read that completes without a data strobe
  // returns whatever was captured last.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if ((state_q == WAIT_DONE) && codec_data_out_valid) begin
      rdata_q <= codec_data_out;
    end
  end

  assign req_ready      = grant ? gnt : '0;
  assign codec_wr_en    = (state_q == ISSUE) &&  is_write_q;
  assign codec_rd_en    = (state_q == ISSUE) && !is_write_q;
  assign codec_reg_addr = addr_q;
  assign codec_data_in  = wdata_q;
  assign rsp_valid      = (state_q == RESP) ? owner_oh : '0;
  assign rsp_error      = ((state_q == RESP) && err_q) ? owner_oh : '0;
  assign rsp_rdata      = ((state_q == RESP) && !is_write_q && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_codec_reg_arbiter.sv
module tb_codec_reg_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_write;
  logic [8*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_rdata;
  logic [N-1:0]   rsp_error;
  logic           codec_rd_en;
  logic           codec_wr_en;
  logic [7:0]     codec_reg_addr;
  logic [7:0]     codec_data_in;
  logic [7:0]     codec_data_out;
  logic           codec_data_out_valid;
  logic           controller_busy;

  codec_reg_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_write            (req_write),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .req_ready            (req_ready),
    .rsp_valid            (rsp_valid),
    .rsp_rdata            (rsp_rdata),
    .rsp_error            (rsp_error),
    .codec_rd_en          (codec_rd_en),
    .codec_wr_en          (codec_wr_en),
    .codec_reg_addr       (codec_reg_addr),
    .codec_data_in        (codec_data_in),
    .codec_data_out       (codec_data_out),
    .codec_data_out_valid (codec_data_out_valid),
    .controller_busy      (controller_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- controller model ----------------
  bit         force_busy = 1'b0;
  int         m_delay    = 0;
  int         m_hold     = 2;
  bit         m_never    = 1'b0;
  bit         m_valid_en = 1'b1;
  logic [7:0] m_rdata    = 8'h00;
  int         busy_fall_cyc = -1;

  initial begin
    int  phase;
    int  mcnt;
    bit  was_rd;
    phase = 0; mcnt = 0; was_rd = 1'b0;
    controller_busy      = 1'b0;
    codec_data_out       = 8'h00;
    codec_data_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      codec_data_out_valid = 1'b0;
      if (reset) begin
        phase = 0;
        controller_busy = force_busy;
      end else if (force_busy) begin
        phase = 0;
        controller_busy = 1'b1;
      end else begin
        case (phase)
          0: begin
            if (controller_busy) busy_fall_cyc = cyc;
            controller_busy = 1'b0;
            if ((codec_wr_en || codec_rd_en) && !m_never) begin
              was_rd = codec_rd_en;
              if (m_delay == 0) begin
                controller_busy = 1'b1; phase = 2; mcnt = m_hold;
              end else begin
                phase = 1; mcnt = m_delay;
              end
            end
          end
          1: begin
            mcnt--;
            if (mcnt == 0) begin
              controller_busy = 1'b1; phase = 2; mcnt = m_hold;
            end
          end
          default: begin
            mcnt--;
            if (mcnt == 0) begin
              controller_busy = 1'b0; phase = 0;
              if (was_rd && m_valid_en) begin
                codec_data_out_valid = 1'b1;
                codec_data_out       = m_rdata;
              end
            end
          end
        endcase
      end
    end
  end

  // ---------------- event monitor ----------------
  int         g_q[$];
  int         g_cyc[$];
  logic [N-1:0] r_vec_q[$];
  logic [7:0] r_dat_q[$];
  int         r_cyc_q[$];
  int         multi_rdy = 0;
  int         bad_rsp   = 0;
  int         n_wr = 0, n_rd = 0, n_rsp = 0;
  logic [7:0] s_addr, s_data;
  int         s_cyc = 0;
  logic [N-1:0] r_err = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) begin g_q.push_back(i); break; end
        g_cyc.push_back(cyc);
        if ($countones(req_ready) != 1) multi_rdy++;
      end
      if (codec_wr_en || codec_rd_en) begin
        if (codec_wr_en) n_wr++;
        if (codec_rd_en) n_rd++;
        s_addr = codec_reg_addr;
        s_data = codec_data_in;
        s_cyc  = cyc;
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        r_vec_q.push_back(rsp_valid);
        r_dat_q.push_back(rsp_rdata);
        r_cyc_q.push_back(cyc);
        r_err = rsp_error;
        if (!$onehot(rsp_valid)) bad_rsp++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int bg, brsp, bwr, brd;

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic mark();
    bg = g_q.size(); brsp = n_rsp; bwr = n_wr; brd = n_rd;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
    req_valid[i]       = 1'b1;
    req_write[i]       = wr;
    req_addr[8*i +: 8]  = a;
    req_wdata[8*i +: 8] = d;
  endtask

  task automatic wait_grant(input int target, input int budget, input string tag);
    int k = 0;
    while ((g_q.size() - bg) < target && k < budget) begin step(1); k++; end
    check(tag, 32'((g_q.size() - bg) >= target), 32'd1);
  endtask

  task automatic wait_rsp(input int target, input int budget, input string tag);
    int k = 0;
    while ((n_rsp - brsp) < target && k < budget) begin step(1); k++; end
    check(tag, 32'((n_rsp - brsp) >= target), 32'd1);
  endtask

  // one full transaction from a single requester: grant, drop, completion
  task automatic one_txn(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input string tag);
    mark();
    set_req(i, wr, a, d);
    wait_grant(1, 20, {tag, "_grant"});
    step(1);
    req_valid = '0;
    wait_rsp(1, 60, {tag, "_rsp"});
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;

    // Reset state, with all three requests already pending.
    m_delay = 0; m_hold = 2; m_valid_en = 1'b1; m_rdata = 8'h5A;
    set_req(0, 1'b1, 8'h01, 8'h11);
    set_req(1, 1'b0, 8'h02, 8'h00);
    set_req(2, 1'b1, 8'h03, 8'h33);
    step(3);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_strobes",   {codec_rd_en, codec_wr_en}, 0);
    check("rst_addr_data", {codec_reg_addr, codec_data_in}, 0);
    mark();
    reset = 1'b0;

    // Fairness: requests held from reset -> 0,1,2,0,1,2.
    wait_grant(6, 60, "fair_grant_wait");
    req_valid = '0;
    wait_rsp(6, 40, "fair_rsp_wait");
    step(8);
    check("fair_ngrant", g_q.size() - bg, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fair_order%0d", k), g_q[bg + k], k % 3);
      check($sformatf("fair_rsp_owner%0d", k), r_vec_q[brsp + k], 32'(1) << (k % 3));
    end
    check("fair_multi_ready", multi_rdy, 0);
    check("fair_rsp_onehot", bad_rsp, 0);
    check("fair_grant_gap", g_cyc[bg + 1] - g_cyc[bg], 5);
    check("fair_latency", r_cyc_q[brsp] - g_cyc[bg], 4);
    check("fair_rd_data1", r_dat_q[brsp + 1], 8'h5A);
    check("fair_wr_data3", r_dat_q[brsp + 3], 8'h00);

    // Single write: busy 2 cycles after wr_en, held 5 cycles.
    m_delay = 2; m_hold = 5;
    one_txn(1, 1'b1, 8'h10, 8'hA5, "wr");
    check("wr_owner", g_q[bg], 1);
    check("wr_nwr", n_wr - bwr, 1);
    check("wr_nrd", n_rd - brd, 0);
    check("wr_addr", s_addr, 8'h10);
    check("wr_data", s_data, 8'hA5);
    check("wr_strobe_lat", s_cyc - g_cyc[bg], 1);
    check("wr_rsp_vec", r_vec_q[brsp], 3'b010);
    check("wr_rsp_err", r_err, 0);
    check("wr_rsp_data", r_dat_q[brsp], 0);
    check("wr_latency", r_cyc_q[brsp] - g_cyc[bg], 9);
    check("wr_nrsp", n_rsp - brsp, 1);

    // Read through an instant controller.
    m_delay = 0; m_hold = 2; m_rdata = 8'h3C; m_valid_en = 1'b1;
    one_txn(0, 1'b0, 8'h22, 8'h00, "rd");
    check("rd_nrd", n_rd - brd, 1);
    check("rd_nwr", n_wr - bwr, 0);
    check("rd_addr", s_addr, 8'h22);
    check("rd_rsp_vec", r_vec_q[brsp], 3'b001);
    check("rd_rsp_data", r_dat_q[brsp], 8'h3C);
    check("rd_rsp_err", r_err, 0);
    check("rd_latency", r_cyc_q[brsp] - g_cyc[bg], 4);

    // Read with no data strobe returns the last captured value.
    m_valid_en = 1'b0; m_rdata = 8'hEE;
    one_txn(2, 1'b0, 8'h05, 8'h00, "rdstale");
    check("rdstale_vec", r_vec_q[brsp], 3'b100);
    check("rdstale_data", r_dat_q[brsp], 8'h3C);
    m_valid_en = 1'b1;

    // Init gating: busy for 100 cycles after reset with req2 pending.
    force_busy = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    mark();
    set_req(2, 1'b1, 8'h33, 8'h77);
    step(100);
    check("init_no_strobe", (n_wr - bwr) + (n_rd - brd), 0);
    check("init_no_grant", g_q.size() - bg, 0);
    force_busy = 1'b0;
    wait_grant(1, 5, "init_grant");
    step(1);
    req_valid = '0;
    wait_rsp(1, 30, "init_rsp");
    step(2);
    check("init_grant_delay", g_cyc[bg] - busy_fall_cyc, 0);
    check("init_owner", g_q[bg], 2);
    check("init_addr_data", {s_addr, s_data}, 16'h3377);
    check("init_rsp_vec", r_vec_q[brsp], 3'b100);

    // Reset while waiting for busy to fall: silent abort.
    m_delay = 0; m_hold = 10;
    mark();
    set_req(1, 1'b0, 8'h44, 8'h00);
    wait_grant(1, 10, "abort_grant");
    req_valid = '0;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("abort_addr", codec_reg_addr, 0);
    check("abort_outputs", {rsp_valid, codec_rd_en, codec_wr_en, rsp_rdata}, 0);
    step(20);
    check("abort_no_rsp", n_rsp - brsp, 0);
    m_hold = 2;
    mark();
    set_req(0, 1'b1, 8'h55, 8'h99);
    set_req(1, 1'b1, 8'h66, 8'h98);
    wait_grant(1, 10, "post_abort_grant");
    step(1);
    req_valid = '0;
    wait_rsp(1, 30, "post_abort_rsp");
    step(2);
    check("post_abort_owner", g_q[bg], 0);
    check("post_abort_rsp_vec", r_vec_q[brsp], 3'b001);
    check("post_abort_addr", s_addr, 8'h55);

`ifdef CODEC_ARB_TIMEOUT_EN
    // Controller never answers: abort after TIMEOUT_CYCLES of waiting.
    m_never = 1'b1;
    one_txn(0, 1'b0, 8'h01, 8'h00, "to");
    check("to_rsp_vec", r_vec_q[brsp], 3'b001);
    check("to_rsp_err", r_err, 3'b001);
    check("to_rsp_data", r_dat_q[brsp], 0);
    check("to_latency", r_cyc_q[brsp] - s_cyc, 21);
    check("to_single_strobe", n_rd - brd, 1);
    m_never = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
